// File: rtl/synch_fifo_ext.sv
// synch_fifo_ext: single-clock FIFO with any depth, threshold flags,
// occupancy counts and sticky overflow/underflow flags.
// Ports: clk, rst_n (sync, active-low), write_en/write_data,
//   read_en/read_data, err_clr, full/empty, almost_full/almost_empty,
//   room_avail/data_avail (FIFO_PTR+1 bits), overflow/underflow.
// Define SYNCH_FIFO_FWFT_EN for first-word-fall-through read_data;
// otherwise read_data is registered with one cycle of latency.
module synch_fifo_ext #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_PTR   = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_en,
  input  logic [FIFO_WIDTH-1:0] write_data,
  input  logic                  read_en,
  input  logic                  err_clr,
  output logic [FIFO_WIDTH-1:0] read_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [FIFO_PTR:0]     room_avail,
  output logic [FIFO_PTR:0]     data_avail,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW = FIFO_PTR + 1;

  localparam logic [FIFO_PTR-1:0] LAST =
    FIFO_PTR'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE    = CW'(AE_THRESH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [FIFO_PTR-1:0]   wr_ptr;
  logic [FIFO_PTR-1:0]   rd_ptr;
  logic [CW-1:0]         count;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  ovf;
  logic                  unf;

  // Every status output comes straight from the occupancy register.
  assign full         = (count == DEPTH);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF);
  assign almost_empty = (count <= AE);
  assign room_avail   = DEPTH - count;
  assign data_avail   = count;
  assign overflow     = ovf;
  assign underflow    = unf;

  // A full FIFO refuses writes even when a read pops in the same cycle.
  assign wr_ok = write_en && !full;
  assign rd_ok = read_en && !empty;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [FIFO_PTR-1:0] bump(
    input logic [FIFO_PTR-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= bump(wr_ptr);
      if (rd_ok) rd_ptr <= bump(rd_ptr);
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new error event beats a same-cycle clear.
      if (write_en && full) ovf <= 1'b1;
      else if (err_clr)     ovf <= 1'b0;
      if (read_en && empty) unf <= 1'b1;
      else if (err_clr)     unf <= 1'b0;
    end
  end

  // Storage is never cleared; writes during reset are dropped.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) mem[wr_ptr] <= write_data;
  end

`ifdef SYNCH_FIFO_FWFT_EN
  assign read_data = empty ? '0 : mem[rd_ptr];
`else
  logic [FIFO_WIDTH-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (!rst_n)     rdata_reg <= '0;
    else if (rd_ok) rdata_reg <= mem[rd_ptr];
  end

  assign read_data = rdata_reg;
`endif

endmodule

// File: tb/tb_synch_fifo_ext.sv
// tb_synch_fifo_ext: drives a depth-8 and a depth-6 instance with the
// same stimulus and checks both against a queue-based model.
module tb_synch_fifo_ext;

  typedef logic [15:0] wq_t [$];

  typedef struct {
    logic        we;
    logic [15:0] wd;
    logic        re;
    logic        ec;
    int          cnt;
    logic        ovf;
    logic        unf;
    logic [15:0] rd;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        write_en;
  logic        read_en;
  logic        err_clr;
  logic [15:0] write_data;

  logic [15:0] rd_a, rd_b;
  logic        full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
  logic        full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
  logic [3:0]  room_a, avail_a, room_b, avail_b;

  int checks = 0;
  int errors = 0;

  wq_t         qa, qb;
  logic        oa, ua, ob, ub;
  logic [15:0] la, lb;

  vec_t tbl [22];

  synch_fifo_ext u_a (
    .clk(clk), .rst_n(rst_n),
    .write_en(write_en), .write_data(write_data),
    .read_en(read_en), .err_clr(err_clr),
    .read_data(rd_a), .full(full_a), .empty(empty_a),
    .almost_full(af_a), .almost_empty(ae_a),
    .room_avail(room_a), .data_avail(avail_a),
    .overflow(ovf_a), .underflow(unf_a)
  );

  synch_fifo_ext #(
    .FIFO_WIDTH(16), .FIFO_DEPTH(6), .FIFO_PTR(3),
    .AF_THRESH(5), .AE_THRESH(1)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .write_en(write_en), .write_data(write_data),
    .read_en(read_en), .err_clr(err_clr),
    .read_data(rd_b), .full(full_b), .empty(empty_b),
    .almost_full(af_b), .almost_empty(ae_b),
    .room_avail(room_b), .data_avail(avail_b),
    .overflow(ovf_b), .underflow(unf_b)
  );

  task automatic cmp(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference behaviour: a word queue plus sticky flags.
  task automatic mstep(inout wq_t q, inout logic ov,
                       inout logic un, inout logic [15:0] lr,
                       input int d);
    int n;
    n = q.size();
    if (!rst_n) begin
      q.delete();
      ov = 1'b0;
      un = 1'b0;
      lr = 16'h0;
    end else begin
      if (err_clr) begin
        ov = 1'b0;
        un = 1'b0;
      end
      if (write_en && n == d) ov = 1'b1;
      if (read_en && n == 0)  un = 1'b1;
      if (read_en && n > 0)   lr = q.pop_front();
      if (write_en && n < d)  q.push_back(write_data);
    end
  endtask

  function automatic logic [15:0] exp_rd(input wq_t q,
                                         input logic [15:0] lr);
    logic [15:0] r;
`ifdef SYNCH_FIFO_FWFT_EN
    r = (q.size() > 0) ? q[0] : 16'h0;
    if (lr === 16'hx) r = 16'hx;
`else
    r = lr;
    if (q.size() < 0) r = 16'hx;
`endif
    return r;
  endfunction

  task automatic chk(input string p, input wq_t q,
                     input logic ov, input logic un,
                     input logic [15:0] lr, input int d,
                     input int af, input int ae,
                     input logic [15:0] rd, input logic fu,
                     input logic em, input logic afl,
                     input logic ael, input logic o,
                     input logic u, input logic [3:0] room,
                     input logic [3:0] avail);
    int n;
    n = q.size();
    cmp({p, ".data_avail"}, 32'(avail), 32'(n));
    cmp({p, ".room_avail"}, 32'(room), 32'(d - n));
    cmp({p, ".full"}, 32'(fu), 32'(n == d));
    cmp({p, ".empty"}, 32'(em), 32'(n == 0));
    cmp({p, ".almost_full"}, 32'(afl), 32'(n >= af));
    cmp({p, ".almost_empty"}, 32'(ael), 32'(n <= ae));
    cmp({p, ".overflow"}, 32'(o), 32'(ov));
    cmp({p, ".underflow"}, 32'(u), 32'(un));
    cmp({p, ".read_data"}, 32'(rd), 32'(exp_rd(q, lr)));
  endtask

  task automatic drive(input logic we, input logic [15:0] wd,
                       input logic re, input logic ec);
    write_en   = we;
    write_data = wd;
    read_en    = re;
    err_clr    = ec;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    mstep(qa, oa, ua, la, 8);
    mstep(qb, ob, ub, lb, 6);
    #1;
    chk({tag, ".a"}, qa, oa, ua, la, 8, 6, 2, rd_a,
        full_a, empty_a, af_a, ae_a, ovf_a, unf_a,
        room_a, avail_a);
    chk({tag, ".b"}, qb, ob, ub, lb, 6, 5, 1, rd_b,
        full_b, empty_b, af_b, ae_b, ovf_b, unf_b,
        room_b, avail_b);
  endtask

  int  nwr_b;
  bit  seen_full_b;
  bit  seen_empty_b;
  int  pw;
  int  pr;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    la = 16'h0;
    lb = 16'h0;
    oa = 1'b0;
    ua = 1'b0;
    ob = 1'b0;
    ub = 1'b0;

    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, 16'(~(i + 1)), 1'b0, 1'b0,
                 i + 1, 1'b0, 1'b0, 16'h0};
    tbl[8] = '{1'b1, 16'hAAAA, 1'b0, 1'b0, 8, 1'b1, 1'b0, 16'h0};
    for (int j = 0; j < 8; j++)
      tbl[9 + j] = '{1'b0, 16'h0, 1'b1, 1'b0,
                     7 - j, 1'b1, 1'b0, 16'(~(j + 1))};
    tbl[17] = '{1'b0, 16'h0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 16'hFFF7};
    tbl[18] = '{1'b0, 16'h0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 16'hFFF7};
    tbl[19] = '{1'b0, 16'h0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 16'hFFF7};
    tbl[20] = '{1'b0, 16'h0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 16'hFFF7};
    tbl[21] = '{1'b0, 16'h0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 16'hFFF7};

    step("rst0");
    step("rst1");
    cmp("rst.empty", 32'(empty_a), 32'd1);
    cmp("rst.room", 32'(room_a), 32'd8);
    cmp("rst.read_data", 32'(rd_a), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].we, tbl[i].wd, tbl[i].re, tbl[i].ec);
      step($sformatf("tbl%0d", i));
      cmp($sformatf("tbl%0d.cnt", i), 32'(avail_a), 32'(tbl[i].cnt));
      cmp($sformatf("tbl%0d.full", i), 32'(full_a),
          32'(tbl[i].cnt == 8));
      cmp($sformatf("tbl%0d.af", i), 32'(af_a),
          32'(tbl[i].cnt >= 6));
      cmp($sformatf("tbl%0d.ovf", i), 32'(ovf_a), 32'(tbl[i].ovf));
      cmp($sformatf("tbl%0d.unf", i), 32'(unf_a), 32'(tbl[i].unf));
`ifndef SYNCH_FIFO_FWFT_EN
      cmp($sformatf("tbl%0d.rd", i), 32'(rd_a), 32'(tbl[i].rd));
`endif
    end

    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'(16'h100 + i), 1'b0, 1'b0);
      step("sim.fill");
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 16'(16'h200 + k), 1'b1, 1'b0);
      step("sim.rw");
      cmp("sim.data_avail", 32'(avail_a), 32'd4);
`ifndef SYNCH_FIFO_FWFT_EN
      cmp("sim.order", 32'(rd_a), 32'(16'h100 + k));
`endif
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 16'h0, 1'b1, 1'b0);
      step("sim.drain");
    end

    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'(16'h300 + i), 1'b0, 1'b0);
      step("mid.fill");
    end
    rst_n = 1'b0;
    drive(1'b1, 16'hBEEF, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step("mid.rst");
      cmp("mid.room", 32'(room_a), 32'd8);
      cmp("mid.read_data", 32'(rd_a), 32'd0);
    end
    rst_n = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    step("mid.idle");

`ifdef SYNCH_FIFO_FWFT_EN
    drive(1'b1, 16'h1234, 1'b0, 1'b0);
    step("fwft.w1");
    cmp("fwft.first", 32'(rd_a), 32'h1234);
    drive(1'b1, 16'h5678, 1'b0, 1'b0);
    step("fwft.w2");
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    step("fwft.pop");
    cmp("fwft.second", 32'(rd_a), 32'h5678);
    step("fwft.pop2");
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    step("fwft.idle");
`endif

    nwr_b = 0;
    seen_full_b = 1'b0;
    seen_empty_b = 1'b0;
    for (int c = 0; c < 300; c++) begin
      pw = (c < 100) ? 70 : (c < 200) ? 30 : 50;
      pr = 100 - pw;
      drive($urandom_range(0, 99) < pw, 16'($urandom),
            $urandom_range(0, 99) < pr,
            $urandom_range(0, 99) < 4);
      if (write_en && qb.size() < 6) nwr_b++;
      step($sformatf("rnd%0d", c));
      if (full_b) seen_full_b = 1'b1;
      if (empty_b && c >= 100) seen_empty_b = 1'b1;
    end
    cmp("rnd.b_writes_ge_40", 32'(nwr_b >= 40), 32'd1);
    cmp("rnd.b_hit_full", 32'(seen_full_b), 32'd1);
    cmp("rnd.b_hit_empty", 32'(seen_empty_b), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/synch_fifo_ext.md
# synch_fifo_ext

Parametrised next-generation synchronous FIFO: single clock, arbitrary (non-power-of-two) depth, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and occupancy counts. It replaces the basic synch_fifo wherever producers and consumers need early back-pressure or error visibility. Storage is a register array; an optional first-word-fall-through read mode is selected at compile time.

## Interface
- FIFO_WIDTH, 16, data word width in bits
- FIFO_DEPTH, 8, number of entries; 2 ≤ FIFO_DEPTH ≤ 2**FIFO_PTR; need not be a power of two
- FIFO_PTR, 3, pointer width in bits; count outputs are FIFO_PTR+1 bits
- AF_THRESH, 6, almost_full asserts when occupancy ≥ AF_THRESH
- AE_THRESH, 2, almost_empty asserts when occupancy ≤ AE_THRESH; 0 ≤ AE_THRESH < AF_THRESH ≤ FIFO_DEPTH
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  reset, synchronous, active-low
- write_en  input  1  write request
- write_data  input  FIFO_WIDTH  write word
- read_en  input  1  read request
- err_clr  input  1  clears overflow and underflow
- read_data  output  FIFO_WIDTH  read word
- full, empty  output  1 each  occupancy == FIFO_DEPTH / occupancy == 0
- almost_full, almost_empty  output  1 each  threshold flags
- room_avail  output  FIFO_PTR+1  FIFO_DEPTH − occupancy
- data_avail  output  FIFO_PTR+1  occupancy
- overflow, underflow  output  1 each  sticky error flags

## Operation
- A write is accepted iff write_en && !full. A read is accepted iff read_en && !empty. When full, a write is rejected even if a read is accepted in the same cycle.
- wr_ptr and rd_ptr advance by 1 on each accepted access and wrap from FIFO_DEPTH−1 to 0 (explicit compare, not modulo-2**FIFO_PTR).
- The occupancy register increments on a write-only cycle, decrements on a read-only cycle, and is unchanged on a cycle with both a write and a read.
- All status outputs are decoded from the registered occupancy. No other logic feeds them.
- overflow is set by write_en && full. underflow is set by read_en && empty. Both hold until err_clr or reset. If a set and err_clr occur in the same cycle, the set wins.
- A rejected access changes no pointer, occupancy or memory state.
- Standard read mode: read_data is registered. It loads mem[rd_ptr] on an accepted read and otherwise holds its value.
- Reset (rst_n low at an edge):
  - pointers, occupancy, read_data and error flags are cleared;
  - memory contents are not cleared;
  - any concurrent write or read is ignored.
- Reset values: read_data=0, empty=1, full=0, almost_empty=1, almost_full=0, room_avail=FIFO_DEPTH, data_avail=0, overflow=0, underflow=0.

## Timing
- Write-to-visible: a word written at edge N is readable from edge N (occupancy updates at N).
- Standard mode: an accepted read at edge N presents the word on read_data after edge N (1-cycle latency).
- All flags and counts change at the same edge as the access that causes the change. There is no extra flag latency.
- Reset mid-operation takes effect at the first edge with rst_n=0. Normal operation resumes at the first edge with rst_n=1.

## Configuration
- SYNCH_FIFO_FWFT_EN defined: first-word-fall-through mode.
  - read_data is combinational mem[rd_ptr] when !empty and 0 when empty.
  - read_en pops the current head, and the next word appears after that edge.
  - A write into an empty FIFO at edge N shows the word on read_data after edge N with no read_en.
- SYNCH_FIFO_FWFT_EN undefined: standard registered read mode as described above.

## Test plan
- Reset: hold rst_n=0 for 3 edges mid-traffic with 5 words stored -> empty=1, full=0, room_avail=8, data_avail=0, read_data=0, overflow=underflow=0.
- Fill/overflow:
  - write 8 words ~(i+1), i=0..7 -> almost_full=1 after the 6th write edge, full=1 and room_avail=0 after the 8th;
  - a 9th write -> overflow=1 and data_avail stays 8;
  - 8 reads -> 0xFFFE, 0xFFFD … 0xFFF7 in order, with empty=1 after the last.
- Simultaneous access: at data_avail=4, assert write_en and read_en together for 3 cycles -> data_avail stays 4 and the output order is preserved.
- Underflow: read_en while empty -> underflow=1 and read_data unchanged. err_clr for 1 cycle -> underflow=0 after that edge. err_clr together with read_en while empty -> underflow stays 1.
- Non-power-of-two wrap: FIFO_DEPTH=6, FIFO_PTR=3, AF_THRESH=5, AE_THRESH=1. Run 40 random writes interleaved with reads, keeping occupancy between 0 and 6 -> all data in order, full exactly at data_avail=6, pointers wrap from 5 to 0.
- FWFT build (SYNCH_FIFO_FWFT_EN): write 0x1234 into an empty FIFO -> read_data=0x1234 after that edge without read_en. Then write 0x5678 and pulse read_en -> read_data=0x5678 after the pop edge.
